// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : operation/state enums, funct7 codes and decode helper for alu_mc_exec
// Rev 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ADD_OP   = 2'b00,
        SUB_OP   = 2'b01,
        RTYPE_OP = 2'b10
    } alu_op_e;

    typedef enum logic [4:0] {
        CTRL_ADD    = 5'd0,
        CTRL_SUB    = 5'd1,
        CTRL_SLL    = 5'd2,
        CTRL_SLT    = 5'd3,
        CTRL_SLTU   = 5'd4,
        CTRL_XOR    = 5'd5,
        CTRL_SRL    = 5'd6,
        CTRL_SRA    = 5'd7,
        CTRL_OR     = 5'd8,
        CTRL_AND    = 5'd9,
        CTRL_MUL    = 5'b10000,
        CTRL_MULH   = 5'b10001,
        CTRL_MULHSU = 5'b10010,
        CTRL_MULHU  = 5'b10011,
        CTRL_DIV    = 5'b10100,
        CTRL_DIVU   = 5'b10101,
        CTRL_REM    = 5'b10110,
        CTRL_REMU   = 5'b10111
    } alu_ctrl_e;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    // M-ext codes mirror funct3 in the low bits so bit 4 alone flags a mul/div.
    function automatic alu_ctrl_e alu_decode(input logic [1:0] op, input logic [6:0] f7,
                                             input logic [2:0] f3, input logic mext);
        alu_ctrl_e c;
        c = CTRL_ADD;
        if (op == SUB_OP) begin
            c = CTRL_SUB;
        end else if (op == RTYPE_OP) begin
            if (f7 == FUNCT7_BASE) begin
                case (f3)
                    3'b000:  c = CTRL_ADD;
                    3'b001:  c = CTRL_SLL;
                    3'b010:  c = CTRL_SLT;
                    3'b011:  c = CTRL_SLTU;
                    3'b100:  c = CTRL_XOR;
                    3'b101:  c = CTRL_SRL;
                    3'b110:  c = CTRL_OR;
                    default: c = CTRL_AND;
                endcase
            end else if (f7 == FUNCT7_ALT) begin
                if (f3 == 3'b000)      c = CTRL_SUB;
                else if (f3 == 3'b101) c = CTRL_SRA;
            end else if (mext && (f7 == FUNCT7_MEXT)) begin
                c = alu_ctrl_e'({2'b10, f3});
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_exec_if.sv
`default_nettype none
// ============================================================================
// alu_mc_exec_if : issue-side and writeback-side handshake bundle of alu_mc_exec
// Rev 1.0
// ============================================================================
interface alu_mc_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      fun7;
    logic [2:0]      fun3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, alu_op, fun7, fun3, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_op, fun7, fun3, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// alu_muldiv_iter : bit-serial shift-add multiplier / restoring divider (RV_MEXT_EN only)
// Rev 1.0
// ============================================================================
`ifdef RV_MEXT_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  alu_ctrl_e       ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);

    logic              running_q, running_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_n;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              div_q, div_d, neg_q, neg_d, hi_q, hi_d;

    logic              signed_a, signed_b, a_neg, b_neg, is_div;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_sel, div_out;

    always_comb begin
        signed_a = ctrl inside {CTRL_MULH, CTRL_MULHSU, CTRL_DIV, CTRL_REM};
        signed_b = ctrl inside {CTRL_MULH, CTRL_DIV, CTRL_REM};
        is_div   = ctrl inside {CTRL_DIV, CTRL_DIVU, CTRL_REM, CTRL_REMU};
        a_neg    = signed_a && op_a[XLEN-1];
        b_neg    = signed_b && op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
    end

    // acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial   = rem_sh - {1'b0, opb_q};
        if (!div_q)
            acc_n = {mul_sum, acc_q[XLEN-1:1]};
        else if (!trial[XLEN])
            acc_n = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_n = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    assign done = running_q && (cnt_q == CW'(XLEN - 1));

    // Final step and sign fix-up are combinational so the top can register on the last iteration.
    always_comb begin
        prod    = neg_q ? -acc_n : acc_n;
        div_sel = hi_q ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
        div_out = neg_q ? -div_sel : div_sel;
        res     = div_q ? div_out : (hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
    end

    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        div_d     = div_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        if (flush) begin
            running_d = 1'b0;
        end else if (start) begin
            running_d = 1'b1;
            cnt_d     = '0;
            acc_d     = {{XLEN{1'b0}}, mag_a};
            opb_d     = mag_b;
            div_d     = is_div;
            neg_d     = (ctrl == CTRL_REM) ? a_neg : (a_neg ^ b_neg);
            hi_d      = ctrl inside {CTRL_MULH, CTRL_MULHSU, CTRL_MULHU, CTRL_REM, CTRL_REMU};
        end else if (running_q) begin
            acc_d = acc_n;
            cnt_d = cnt_q + 1'b1;
            if (done) running_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            hi_q      <= 1'b0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
        end
    end
endmodule
`endif
`default_nettype wire

// File: rtl/alu_mc_exec.sv
`default_nettype none
// ============================================================================
// alu_mc_exec : execute-stage ALU, 1-cycle base ops, iterative mul/div when RV_MEXT_EN is defined
// Rev 1.0
// ============================================================================
module alu_mc_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    alu_mc_exec_if.slave bus
);
`ifdef RV_MEXT_EN
    localparam logic MEXT_EN = 1'b1;
`else
    localparam logic MEXT_EN = 1'b0;
`endif

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;

    alu_ctrl_e       ctrl;
    logic            accept, needs_iter, md_done;
    logic [XLEN-1:0] base_res, fast_res, md_res;
    logic [SHW-1:0]  shamt;

    assign ctrl   = alu_decode(bus.alu_op, bus.fun7, bus.fun3, MEXT_EN);
    assign shamt  = bus.op_b[SHW-1:0];

    assign bus.in_ready = rst_n && !flush &&
                          ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        base_res = bus.op_a + bus.op_b;
        case (ctrl)
            CTRL_SUB:  base_res = bus.op_a - bus.op_b;
            CTRL_SLL:  base_res = bus.op_a << shamt;
            CTRL_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            CTRL_SLTU: base_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            CTRL_XOR:  base_res = bus.op_a ^ bus.op_b;
            CTRL_SRL:  base_res = bus.op_a >> shamt;
            CTRL_SRA:  base_res = $unsigned($signed(bus.op_a) >>> shamt);
            CTRL_OR:   base_res = bus.op_a | bus.op_b;
            CTRL_AND:  base_res = bus.op_a & bus.op_b;
            default:   base_res = bus.op_a + bus.op_b;
        endcase
    end

`ifdef RV_MEXT_EN
    logic            md_start, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign div_zero = (bus.op_b == '0);
    assign div_ovf  = (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);

    // Divide-by-zero and signed overflow have fixed answers, so they bypass the iterator.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        case (ctrl)
            CTRL_DIV: begin
                if (div_zero) begin
                    special = 1'b1; special_res = '1;
                end else if (div_ovf) begin
                    special = 1'b1; special_res = bus.op_a;
                end
            end
            CTRL_DIVU: if (div_zero) begin special = 1'b1; special_res = '1; end
            CTRL_REM: begin
                if (div_zero) begin
                    special = 1'b1; special_res = bus.op_a;
                end else if (div_ovf) begin
                    special = 1'b1; special_res = '0;
                end
            end
            CTRL_REMU: if (div_zero) begin special = 1'b1; special_res = bus.op_a; end
            default: ;
        endcase
    end

    assign needs_iter = ctrl[4] && !special;
    assign fast_res   = special ? special_res : base_res;
    assign md_start   = accept && needs_iter;
    assign bus.busy   = (state_q == ST_CALC);

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (md_start),
        .ctrl  (ctrl),
        .op_a  (bus.op_a),
        .op_b  (bus.op_b),
        .done  (md_done),
        .res   (md_res)
    );
`else
    assign needs_iter = 1'b0;
    assign fast_res   = base_res;
    assign md_done    = 1'b0;
    assign md_res     = '0;
    assign bus.busy   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept && needs_iter) begin
                        state_d     = ST_CALC;
                        out_valid_d = 1'b0;
                    end else if (accept) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        result_d    = fast_res;
                        zero_d      = (fast_res == '0);
                    end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                ST_CALC: begin
                    if (md_done) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        result_d    = md_res;
                        zero_d      = (md_res == '0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = out_valid_q && zero_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_mc_exec.sv
`default_nettype none
// ============================================================================
// tb_alu_mc_exec : directed vector bench for alu_mc_exec (XLEN=32), M tests under RV_MEXT_EN
// Rev 1.0
// ============================================================================
module tb_alu_mc_exec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_mc_exec_if #(.XLEN(32)) bus ();

    alu_mc_exec #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.fun7   = f7;
        bus.fun3   = f3;
        bus.op_a   = a;
        bus.op_b   = b;
    endtask

    // Issues one op from IDLE/HOLD with out_ready=1, then scrambles operands and counts cycles to out_valid.
    task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc, output logic busy_seen);
        drive(op, f7, f3, a, b);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.op_a     = 32'hDEADBEEF;
        bus.op_b     = 32'h12345678;
        cyc          = 1;
        busy_seen    = 1'b0;
        while (!bus.out_valid && cyc < 200) begin
            busy_seen = busy_seen | bus.busy;
            tick();
            cyc++;
        end
        res = bus.result;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          cyc;
        logic        bz;
        logic        seen;

        vecs[0]  = '{2'b10, 7'h20, 3'b101, 32'h80000000, 32'd4,        32'hF8000000};
        vecs[1]  = '{2'b10, 7'h00, 3'b101, 32'h80000000, 32'd4,        32'h08000000};
        vecs[2]  = '{2'b10, 7'h00, 3'b000, 32'd5,        32'd3,        32'd8};
        vecs[3]  = '{2'b10, 7'h20, 3'b000, 32'd5,        32'd7,        32'hFFFFFFFE};
        vecs[4]  = '{2'b10, 7'h00, 3'b001, 32'd1,        32'h21,       32'd2};
        vecs[5]  = '{2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd1};
        vecs[6]  = '{2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[7]  = '{2'b10, 7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vecs[8]  = '{2'b10, 7'h00, 3'b110, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
        vecs[9]  = '{2'b10, 7'h00, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[10] = '{2'b01, 7'h00, 3'b000, 32'd3,        32'd3,        32'd0};
        vecs[11] = '{2'b00, 7'h20, 3'b101, 32'd10,       32'd20,       32'd30};
        vecs[12] = '{2'b11, 7'h20, 3'b000, 32'd1,        32'd2,        32'd3};
        vecs[13] = '{2'b10, 7'h20, 3'b001, 32'd4,        32'd5,        32'd9};
        vecs[14] = '{2'b10, 7'h02, 3'b100, 32'd4,        32'd5,        32'd9};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 7'h00, 3'b000, 32'd0, 32'd0);

        // reset values while rst_n is low
        repeat (2) tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result",    bus.result,             32'd0);
        check("rst_zero",      {31'd0, bus.zero},      32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // back-to-back base ops, one result per cycle
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b);
            bus.in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), {31'd0, bus.zero}, {31'd0, vecs[i].exp == 32'd0});
        end
        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // backpressure: three ADDs with out_ready low
        bus.out_ready = 1'b0;
        drive(2'b00, 7'h00, 3'b000, 32'd1, 32'd1);
        bus.in_valid = 1'b1;
        tick();
        drive(2'b00, 7'h00, 3'b000, 32'd2, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_result", i), bus.result, 32'd2);
            check($sformatf("bp_hold%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_first_result", bus.result, 32'd2);
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("bp_second_result", bus.result, 32'd4);
        drive(2'b00, 7'h00, 3'b000, 32'd3, 32'd3);
        tick();
        check("bp_third_result", bus.result, 32'd6);
        check("bp_third_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        tick();
        check("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef RV_MEXT_EN
        run_op(2'b10, 7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, res, cyc, bz);
        check("mulhu_result", res, 32'hFFFFFFFE);
        check("mulhu_cycles", cyc, 32'd33);
        check("mulhu_busy",   {31'd0, bz}, 32'd1);
        run_op(2'b10, 7'h01, 3'b100, 32'hFFFFFFF9, 32'd2, res, cyc, bz);
        check("div_result", res, 32'hFFFFFFFD);
        check("div_cycles", cyc, 32'd33);
        run_op(2'b10, 7'h01, 3'b110, 32'hFFFFFFF9, 32'd2, res, cyc, bz);
        check("rem_result", res, 32'hFFFFFFFF);
        run_op(2'b10, 7'h01, 3'b000, 32'hFFFFFFFD, 32'd7, res, cyc, bz);
        check("mul_result", res, 32'hFFFFFFEB);
        run_op(2'b10, 7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, res, cyc, bz);
        check("mulh_result", res, 32'h00000000);
        check("mulh_zero", {31'd0, bus.zero}, 32'd1);
        run_op(2'b10, 7'h01, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, res, cyc, bz);
        check("mulhsu_result", res, 32'hFFFFFFFF);
        run_op(2'b10, 7'h01, 3'b111, 32'd7, 32'd3, res, cyc, bz);
        check("remu_result", res, 32'd1);

        run_op(2'b10, 7'h01, 3'b101, 32'd5, 32'd0, res, cyc, bz);
        check("divu0_result", res, 32'hFFFFFFFF);
        check("divu0_cycles", cyc, 32'd1);
        run_op(2'b10, 7'h01, 3'b110, 32'd5, 32'd0, res, cyc, bz);
        check("rem0_result", res, 32'd5);
        check("rem0_cycles", cyc, 32'd1);
        run_op(2'b10, 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, res, cyc, bz);
        check("divovf_result", res, 32'h80000000);
        check("divovf_cycles", cyc, 32'd1);
        check("divovf_busy", {31'd0, bz | bus.busy}, 32'd0);

        // flush a DIV at CALC cycle 10
        drive(2'b10, 7'h01, 3'b100, 32'd100, 32'd7);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("flush_busy_pre", {31'd0, bus.busy}, 32'd1);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_busy_post", {31'd0, bus.busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | bus.out_valid;
            tick();
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);
        run_op(2'b00, 7'h00, 3'b000, 32'd2, 32'd3, res, cyc, bz);
        check("post_flush_add", res, 32'd5);
        check("post_flush_cycles", cyc, 32'd1);
`else
        run_op(2'b10, 7'h01, 3'b000, 32'd6, 32'd7, res, cyc, bz);
        check("nomext_result", res, 32'd13);
        check("nomext_cycles", cyc, 32'd1);
        check("nomext_busy", {31'd0, bz | bus.busy}, 32'd0);
`endif

        // asynchronous reset in the middle of an operation
        drive(2'b10, 7'h01, 3'b100, 32'd100, 32'd7);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_result",    bus.result,             32'd0);
        check("arst_zero",      {31'd0, bus.zero},      32'd0);
        check("arst_busy",      {31'd0, bus.busy},      32'd0);
        check("arst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_mc_exec.md
Name: alu_mc_exec

Overview:
- Parametrised execute-stage ALU for the RISC-V core that succeeds the combinational ALU-control decoder.
- Decodes alu_op/fun7/fun3 internally, then executes the operation.
- Base ops complete in 1 cycle; RV32M/RV64M multiply and divide run iteratively over XLEN cycles.
- Valid/ready on both sides; sits between decode/issue and writeback, with a flush input from branch resolution.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  2  00 ADD (address/I-type), 01 SUB (branch compare), 10 R-type decode, 11 reserved (treated as ADD).
- fun7  in  7  instruction funct7.
- fun3  in  3  instruction funct3.
- op_a  in  XLEN  rs1 operand.
- op_b  in  XLEN  rs2 or immediate operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0; qualified by out_valid.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Reset (async, rst_n low): state IDLE, out_valid 0, result 0, zero 0, busy 0, in_ready 0 while rst_n is low.
- Decode when alu_op=10:
  - fun7[5] selects SUB/SRA; fun7[6] and fun7[4:0] must be zero except the M-ext code 7'b0000001.
  - Base ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Any other fun7/fun3 combination executes ADD.
- Shifts use op_b[SHW-1:0]. SLT/SLTU produce a zero-extended 0/1.
- FSM states IDLE, CALC, HOLD.
- in_ready = (state==IDLE || (state==HOLD && out_ready)) && !flush.
- Accepting a base op: result registered at the next edge, out_valid=1. Latency 1 cycle. Back-to-back issue allowed, throughput 1/cycle.
- Accepting an M op: state CALC, busy=1. XLEN iteration cycles follow, then result registered and out_valid=1. Latency XLEN+1.
- HOLD: result, zero and out_valid stay stable until out_ready=1.
  - If no new accept occurs that cycle, out_valid drops and the FSM returns to IDLE.
- M-op semantics follow RISC-V M exactly:
  - MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Sign handling: operands are converted to magnitude before iterating; the result is negated after.
- Divide-by-zero special cases complete in 1 cycle with no CALC:
  - DIV/DIVU by zero: quotient all ones.
  - REM/REMU by zero: remainder = op_a.
- Signed overflow (most-negative / -1) completes in 1 cycle: DIV = most-negative, REM = 0.
- flush=1 at an edge: state goes to IDLE, out_valid 0, busy 0, any in-flight result is discarded. flush has priority over in_valid and out_ready in the same cycle.
- Inputs are sampled only on accept; op_a/op_b may change during CALC.

Optional Feature:
- Macro RV_MEXT_EN.
- Defined: M-ext decode, CALC state and alu_muldiv_iter are present, behaving as above.
- Undefined:
  - fun7=0000001 decodes as ADD with latency 1.
  - CALC is unreachable and removed; busy is tied 0.
  - No multiplier/divider logic is synthesised.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum (ADD_OP, SUB_OP, RTYPE_OP).
  - alu_ctrl_e 5-bit operation enum for base and M ops.
  - Constants FUNCT7_BASE, FUNCT7_ALT (0100000), FUNCT7_MEXT (0000001).
  - FSM state enum.
- Sub-module alu_muldiv_iter, compiled only under RV_MEXT_EN:
  - Shift-add multiplier and restoring divider, one bit per cycle.
  - Ports start/done; owns the iteration counter and the 2*XLEN accumulator.

Test Plan:
- Base ALU ops: alu_op=10, fun7=0100000, fun3=101, op_a=0x80000000, op_b=4 -> result 0xF8000000 after 1 cycle. Same with fun7=0 -> result 0x08000000.
- Backpressure: issue 3 ADDs with out_ready=0 -> first result held stable and in_ready=0. Raise out_ready -> three results in order, one per cycle.
- Multiply/divide (RV_MEXT_EN defined):
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after exactly 33 cycles.
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
- Divide corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF in 1 cycle.
  - REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000, busy never asserted.
- Flush and reset mid-operation:
  - flush at CALC cycle 10 of a DIV -> out_valid never rises; next ADD 2+3 returns 5 with latency 1.
  - rst_n low mid-CALC -> all outputs 0 immediately.
- Without RV_MEXT_EN: fun7=0000001, fun3=000, op_a=6, op_b=7 -> result 13 (ADD), latency 1, busy stays 0.
